// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: time-multiplexed FIR controller. One sample is accepted per
// handshake. Its taps are issued one per cycle to a single shared, ce-gated,
// pipelined multiplier. The returned products are summed into one result.
module fir_mac_scheduler #(
  parameter int N_TAPS  = 11,
  parameter int DATA_W  = 32,
  parameter int COEF_W  = 8,
  parameter int MUL_LAT = 1,
  parameter int AW      = $clog2(N_TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              coef_busy,
  output logic              mul_ce,
  output logic [DATA_W-1:0] mul_din0,
  output logic [COEF_W-1:0] mul_din1,
  input  logic [DATA_W-1:0] mul_dout
);

  localparam int            DW       = $clog2(MUL_LAT + 1);
  localparam logic [AW-1:0] LAST_TAP = AW'(N_TAPS - 1);
  localparam logic [DW-1:0] DRN_LAST = DW'(MUL_LAT);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_x [N_TAPS];
  logic [COEF_W-1:0]  r_c [N_TAPS];
  logic [DATA_W-1:0]  r_acc;
  logic [AW-1:0]      r_tap;
  logic [DW-1:0]      r_drn;
  logic               r_issue;
  logic [MUL_LAT-1:0] r_vld;
  logic               r_in_ready;
  logic               r_coef_busy;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_mul_ce;
  logic [DATA_W-1:0]  r_din0;
  logic [COEF_W-1:0]  r_din1;

  logic               w_accept;
  logic               w_coef_ok;
  logic [COEF_W-1:0]  w_c0_next;

  // Tap 0 is issued on the accept edge itself. A coefficient written to
  // address 0 on that same edge has to be forwarded straight to the multiplier.
  assign w_accept  = in_valid & r_in_ready;
  assign w_coef_ok = coef_we & (r_state == IDLE) &
                     ({1'b0, coef_addr} < (AW + 1)'(N_TAPS));
  assign w_c0_next = (w_coef_ok && coef_addr == '0) ? coef_wdata : r_c[0];

  assign in_ready  = r_in_ready;
  assign coef_busy = r_coef_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign mul_ce    = r_mul_ce;
  assign mul_din0  = r_din0;
  assign mul_din1  = r_din1;

  // Coefficient bank: only writable while idle and only for in-range addresses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_TAPS; k++) r_c[k] <= '0;
    end else if (w_coef_ok) begin
      r_c[coef_addr] <= coef_wdata;
    end
  end

  // Delay line: x[0] is the newest sample, x[k] is the sample k handshakes ago
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_TAPS; k++) r_x[k] <= '0;
    end else if (w_accept) begin
      r_x[0] <= in_data;
      for (int k = 1; k < N_TAPS; k++) r_x[k] <= r_x[k-1];
    end
  end

  // Sequencer: issue taps, flush the multiplier pipe, then hold the result until taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_tap       <= '0;
      r_drn       <= '0;
      r_issue     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_coef_busy <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_mul_ce    <= 1'b0;
      r_din0      <= '0;
      r_din1      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state     <= MAC;
            r_tap       <= AW'(1);
            r_in_ready  <= 1'b0;
            r_coef_busy <= 1'b1;
            r_mul_ce    <= 1'b1;
            r_issue     <= 1'b1;
            r_din0      <= in_data;
            r_din1      <= w_c0_next;
          end
        end
        MAC: begin
          r_mul_ce <= 1'b1;
          r_issue  <= 1'b1;
          r_din0   <= r_x[r_tap];
          r_din1   <= r_c[r_tap];
          if (r_tap == LAST_TAP) begin
            r_state <= DRAIN;
            r_drn   <= '0;
          end else begin
            r_tap <= r_tap + 1'b1;
          end
        end
        DRAIN: begin
          r_issue <= 1'b0;
          r_din0  <= '0;
          r_din1  <= '0;
          if (r_drn == DRN_LAST) begin
            r_mul_ce <= 1'b0;
            r_state  <= OUT;
          end else begin
            r_mul_ce <= 1'b1;
            r_drn    <= r_drn + 1'b1;
          end
        end
        OUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_acc;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_coef_busy <= 1'b0;
            r_tap       <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Product tracking: a valid bit follows each issued tap through the multiplier pipe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_vld <= '0;
      r_acc <= '0;
    end else if (r_mul_ce) begin
      r_vld[0] <= r_issue;
      for (int i = 1; i < MUL_LAT; i++) r_vld[i] <= r_vld[i-1];
      if (r_vld[MUL_LAT-1]) r_acc <= r_acc + mul_dout;
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb_fir_mac_scheduler: scoreboard bench for the FIR MAC scheduler. The bench
// also stands in for the external one-stage multiplier.
module tb_fir_mac_scheduler;

  localparam int N = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [7:0]  coef_wdata;
  logic        coef_busy;
  logic        mul_ce;
  logic [31:0] mul_din0;
  logic [7:0]  mul_din1;
  logic [31:0] mul_dout;
  logic signed [31:0] mulCoefExt;

  int checks = 0;
  int errors = 0;

  logic [31:0]       modelX [N];
  logic signed [7:0] modelC [N];
  logic [31:0]       expQ [$];

  fir_mac_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_busy  (coef_busy),
    .mul_ce     (mul_ce),
    .mul_din0   (mul_din0),
    .mul_din1   (mul_din1),
    .mul_dout   (mul_dout)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Shared multiplier stand-in: one ce-gated register stage, product wraps to 32 bits
  assign mulCoefExt = {{24{mul_din1[7]}}, mul_din1};
  always @(posedge clk or negedge reset) begin
    if (!reset) mul_dout <= '0;
    else if (mul_ce) mul_dout <= $signed(mul_din0) * mulCoefExt;
  end

  // Reference model: shift the sample into the history and queue the expected filter output
  function automatic void model_accept(input logic [31:0] d);
    logic signed [31:0] y;
    logic signed [31:0] cx;
    y = 0;
    for (int k = N - 1; k > 0; k--) modelX[k] = modelX[k-1];
    modelX[0] = d;
    for (int k = 0; k < N; k++) begin
      cx = 32'(modelC[k]);
      y  = y + $signed(modelX[k]) * cx;
    end
    expQ.push_back(y);
  endfunction

  function automatic logic [31:0] pop_exp();
    if (expQ.size() == 0) return 'x;
    return expQ.pop_front();
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < N; k++) begin
      modelX[k] = '0;
      modelC[k] = '0;
    end
    expQ.delete();
  endfunction

  task automatic coef_write(input logic [3:0] a, input logic [7:0] v, input bit takes);
    coef_we = 1'b1; coef_addr = a; coef_wdata = v;
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (takes && a < N) modelC[a] = v;
  endtask

  task automatic send_sample(input logic [31:0] d);
    int  n;
    bit  taken;
    n = 0; taken = 1'b0;
    in_valid = 1'b1; in_data = d;
    while (!taken && n < 100) begin
      taken = (in_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (taken) model_accept(d);
    else begin
      checks++; errors++;
      $display("[TB] FAIL in_timeout got in_ready=%b want 1 within 100 cycles", in_ready);
    end
  endtask

  task automatic wait_out(output logic [31:0] d, output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    d = out_data;
    if (out_valid !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL out_timeout got out_valid=%b want 1 within 100 cycles", out_valid);
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)     begin errors++; $display("[TB] FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0)    begin errors++; $display("[TB] FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0)    begin errors++; $display("[TB] FAIL rst_out_data got %h want 0", out_data); end
    checks++; if (mul_ce !== 1'b0)       begin errors++; $display("[TB] FAIL rst_mul_ce got %b want 0", mul_ce); end
    checks++; if (mul_din0 !== 32'h0)    begin errors++; $display("[TB] FAIL rst_din0 got %h want 0", mul_din0); end
    checks++; if (mul_din1 !== 8'h0)     begin errors++; $display("[TB] FAIL rst_din1 got %h want 0", mul_din1); end
    checks++; if (coef_busy !== 1'b0)    begin errors++; $display("[TB] FAIL rst_coef_busy got %b want 0", coef_busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (mul_ce !== 1'b0)       begin errors++; $display("[TB] FAIL post_rst_mul_ce got %b want 0", mul_ce); end
  endtask

  task automatic test_impulse();
    logic [31:0] got, want;
    int cyc;
    for (int k = 0; k < N; k++) coef_write(4'(k), 8'(k + 1), 1'b1);
    for (int i = 0; i < 12; i++) begin
      send_sample((i == 0) ? 32'd1 : 32'd0);
      wait_out(got, cyc);
      want = pop_exp();
      checks++;
      if (got !== want) begin errors++; $display("[TB] FAIL impulse[%0d] got %h want %h", i, got, want); end
      take_out();
    end
  endtask

  task automatic test_latency();
    logic [31:0] want;
    int cyc, ceCount;
    send_sample(32'd5);
    ceCount = (mul_ce === 1'b1) ? 1 : 0;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("[TB] FAIL busy_in_ready got %b want 0", in_ready); end
    checks++; if (coef_busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_coef_busy got %b want 1", coef_busy); end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (mul_ce === 1'b1) ceCount++;
    end
    want = pop_exp();
    checks++; if (cyc != 13)          begin errors++; $display("[TB] FAIL latency got %0d want 13", cyc); end
    checks++; if (ceCount != 12)      begin errors++; $display("[TB] FAIL ce_cycles got %0d want 12", ceCount); end
    checks++; if (out_data !== want)  begin errors++; $display("[TB] FAIL latency_data got %h want %h", out_data, want); end
    take_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_drop got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL ready_back got %b want 1", in_ready); end
  endtask

  task automatic test_sign_wrap();
    logic [31:0] got, want;
    int cyc;
    for (int k = 0; k < N; k++) coef_write(4'(k), 8'h00, 1'b1);
    coef_write(4'd0, 8'h80, 1'b1);
    send_sample(32'd3);
    wait_out(got, cyc);
    want = pop_exp();
    checks++; if (got !== want)         begin errors++; $display("[TB] FAIL neg_model got %h want %h", got, want); end
    checks++; if (got !== 32'hFFFFFE80) begin errors++; $display("[TB] FAIL neg_const got %h want FFFFFE80", got); end
    take_out();
    coef_write(4'd0, 8'h02, 1'b1);
    send_sample(32'h7FFFFFFF);
    wait_out(got, cyc);
    want = pop_exp();
    checks++; if (got !== want)         begin errors++; $display("[TB] FAIL wrap_model got %h want %h", got, want); end
    checks++; if (got !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL wrap_const got %h want FFFFFFFE", got); end
    take_out();
  endtask

  task automatic test_backpressure();
    logic [31:0] first, got, want;
    int cyc;
    bit stable;
    send_sample(32'd10);
    wait_out(first, cyc);
    want = pop_exp();
    checks++; if (first !== want) begin errors++; $display("[TB] FAIL bp_first got %h want %h", first, want); end
    in_valid = 1'b1; in_data = 32'h21;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== first || in_ready !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("[TB] FAIL bp_hold got unstable want stable data %h", first); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_drop got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL bp_not_early got in_ready=%b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("[TB] FAIL bp_accept got in_ready=%b want 0", in_ready); end
    model_accept(32'h21);
    wait_out(got, cyc);
    want = pop_exp();
    checks++; if (got !== want) begin errors++; $display("[TB] FAIL bp_second got %h want %h", got, want); end
    take_out();
  endtask

  task automatic test_coef_lockout();
    logic [31:0] got, want;
    int cyc;
    coef_write(4'd0, 8'h01, 1'b1);
    send_sample(32'd7);
    @(posedge clk); #1;
    coef_write(4'd0, 8'h05, 1'b0);
    wait_out(got, cyc);
    want = pop_exp();
    checks++; if (got !== want) begin errors++; $display("[TB] FAIL lock_busy got %h want %h", got, want); end
    take_out();
    coef_write(4'd0, 8'h05, 1'b1);
    coef_write(4'd11, 8'h7F, 1'b0);
    send_sample(32'd7);
    wait_out(got, cyc);
    want = pop_exp();
    checks++; if (got !== want) begin errors++; $display("[TB] FAIL lock_idle got %h want %h", got, want); end
    take_out();
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 8'h03;
    in_valid = 1'b1; in_data = 32'd4;
    @(posedge clk); #1;
    coef_we = 1'b0; in_valid = 1'b0;
    modelC[0] = 8'sh03;
    model_accept(32'd4);
    wait_out(got, cyc);
    want = pop_exp();
    checks++; if (got !== want) begin errors++; $display("[TB] FAIL coef_same_edge got %h want %h", got, want); end
    take_out();
  endtask

  task automatic test_reset_mid_mac();
    logic [31:0] got, want;
    int cyc, seen;
    for (int k = 0; k < N; k++) coef_write(4'(k), 8'(k + 1), 1'b1);
    send_sample(32'd9);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (mul_ce !== 1'b0)   begin errors++; $display("[TB] FAIL rm_mul_ce got %b want 0", mul_ce); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_in_ready got %b want 1", in_ready); end
    reset = 1'b1;
    model_clear();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL rm_no_output got %0d valid cycles want 0", seen); end
    for (int k = 0; k < N; k++) coef_write(4'(k), 8'(k + 1), 1'b1);
    for (int i = 0; i < 2; i++) begin
      send_sample((i == 0) ? 32'd1 : 32'd0);
      wait_out(got, cyc);
      want = pop_exp();
      checks++;
      if (got !== want) begin errors++; $display("[TB] FAIL rm_impulse[%0d] got %h want %h", i, got, want); end
      take_out();
    end
  endtask

  // Bound the whole run in case the DUT stops responding entirely
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no finish want finish within 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence
  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    model_clear();
    test_reset();
    test_impulse();
    test_latency();
    test_sign_wrap();
    test_backpressure();
    test_coef_lockout();
    test_reset_mid_mac();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
